// File: rtl/fir_pkg.sv
// fir_pkg -- shared types and defaults for the two-channel FIR scheduler.
//   state_t         : scheduler FSM states
//   *_DEFAULT       : default tap count, sample width and accumulator width
//   TAPW            : tap index width for the default tap count
//   CNTW            : width of the per-channel result counters
package fir_pkg;

   localparam int NTAPS_DEFAULT = 16;
   localparam int DW_DEFAULT    = 8;
   localparam int ACCW_DEFAULT  = 32;
   localparam int TAPW          = $clog2(NTAPS_DEFAULT);
   localparam int CNTW          = 16;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      MAC  = 3'd2,
      WAIT = 3'd3,
      OUT  = 3'd4
   } state_t;

endpackage

// File: rtl/fir_chan_sched_if.sv
// fir_chan_sched_if -- bundle of every non-clock signal of the scheduler.
//   ch0_* / ch1_*   : per-channel sample offer (valid/data) and acceptance (ready)
//   dp_*            : control towards the external MAC datapath, dp_result back
//   out_*           : result handshake towards the consumer
// Modports:
//   master : the scheduler itself
//   slave  : the environment (channel sources, datapath and consumer)
interface fir_chan_sched_if #(
   parameter int DW   = 8,
   parameter int ACCW = 32,
   parameter int TAPW = 4
);

   logic            ch0_valid;
   logic [DW-1:0]   ch0_data;
   logic            ch0_ready;
   logic            ch1_valid;
   logic [DW-1:0]   ch1_data;
   logic            ch1_ready;

   logic            dp_load;
   logic            dp_chan;
   logic [DW-1:0]   dp_sample;
   logic            dp_acc_clr;
   logic            dp_acc_en;
   logic [TAPW-1:0] dp_tap;
   logic [ACCW-1:0] dp_result;

   logic            out_valid;
   logic [ACCW-1:0] out_data;
   logic            out_chan;
   logic            out_ready;

   modport master (
      input  ch0_valid, ch0_data, ch1_valid, ch1_data, dp_result, out_ready,
      output ch0_ready, ch1_ready, dp_load, dp_chan, dp_sample, dp_acc_clr,
             dp_acc_en, dp_tap, out_valid, out_data, out_chan
   );

   modport slave (
      output ch0_valid, ch0_data, ch1_valid, ch1_data, dp_result, out_ready,
      input  ch0_ready, ch1_ready, dp_load, dp_chan, dp_sample, dp_acc_clr,
             dp_acc_en, dp_tap, out_valid, out_data, out_chan
   );

endinterface

// File: rtl/rr_arb2.sv
// rr_arb2 -- two-requester round-robin arbiter, purely combinational.
//   valid[1:0] : request per channel
//   last       : channel that won the previous grant
//   grant[1:0] : one-hot grant, all zero when nobody requests
module rr_arb2 (
   input  logic [1:0] valid,
   input  logic       last,
   output logic [1:0] grant
);

   // A lone requester always wins; on a tie the channel that did not win
   // last time is served.
   always_comb begin
      grant = 2'b00;
      case (valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/fir_chan_sched.sv
// fir_chan_sched -- schedules two sample channels onto one shared FIR MAC
// datapath: accepts one sample, drives the load/clear/accumulate sequence
// over all taps, captures the accumulator and hands it to the consumer.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : fir_chan_sched_if.master (channel handshakes, datapath
//              control, result handshake)
// Internal cnt0/cnt1 count delivered results per channel (wrapping).
module fir_chan_sched
   import fir_pkg::*;
#(
   parameter int NTAPS = NTAPS_DEFAULT,
   parameter int DW    = DW_DEFAULT,
   parameter int ACCW  = ACCW_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   fir_chan_sched_if.master bus
);

   localparam int TAP_W = (NTAPS > 1) ? $clog2(NTAPS) : 1;
   localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NTAPS - 1);

   state_t            state;
   state_t            state_n;
   logic [1:0]        grant;
   logic              last_grant;
   logic [TAP_W-1:0]  tap;
   logic [DW-1:0]     sample;
   logic              chan;
   logic [ACCW-1:0]   out_data_q;
   logic              out_chan_q;
   logic [CNTW-1:0]   cnt0;
   logic [CNTW-1:0]   cnt1;
   logic              in_hs;
   logic              out_hs;

   rr_arb2 u_arb (
      .valid ({bus.ch1_valid, bus.ch0_valid}),
      .last  (last_grant),
      .grant (grant)
   );

   // grant is only non-zero for a requesting channel, so any grant in IDLE
   // is a completed handshake.
   assign in_hs  = (state == IDLE) && (grant != 2'b00);
   assign out_hs = (state == OUT) && bus.out_ready;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state logic.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (in_hs) state_n = LOAD;
         LOAD:    state_n = MAC;
         MAC:     if (tap == LAST_TAP) state_n = WAIT;
         WAIT:    state_n = OUT;
         OUT:     if (bus.out_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Output decode. Reset is synchronous, so the registers still hold their
   // pre-reset values during the reset cycle; every output is masked with rst
   // so the block looks quiet for the whole time reset is high.
   always_comb begin
      bus.ch0_ready  = 1'b0;
      bus.ch1_ready  = 1'b0;
      bus.dp_load    = 1'b0;
      bus.dp_acc_clr = 1'b0;
      bus.dp_acc_en  = 1'b0;
      bus.out_valid  = 1'b0;
      bus.dp_tap     = '0;
      bus.dp_sample  = '0;
      bus.dp_chan    = 1'b0;
      bus.out_data   = '0;
      bus.out_chan   = 1'b0;
      if (!rst) begin
         bus.ch0_ready  = (state == IDLE) && grant[0];
         bus.ch1_ready  = (state == IDLE) && grant[1];
         bus.dp_load    = (state == LOAD);
         bus.dp_acc_clr = (state == LOAD);
         bus.dp_acc_en  = (state == MAC);
         bus.out_valid  = (state == OUT);
         bus.dp_tap     = tap;
         bus.dp_sample  = sample;
         bus.dp_chan    = chan;
         bus.out_data   = out_data_q;
         bus.out_chan   = out_chan_q;
      end
   end

   // Sample capture, tap counter, result capture and delivery counters.
   // tap is cleared whenever the next cycle is not MAC, so it reads 0 in
   // every other state and starts each MAC run from 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= 1'b1;
         tap        <= '0;
         sample     <= '0;
         chan       <= 1'b0;
         out_data_q <= '0;
         out_chan_q <= 1'b0;
         cnt0       <= '0;
         cnt1       <= '0;
      end else begin
         if (in_hs) begin
            sample     <= grant[1] ? bus.ch1_data : bus.ch0_data;
            chan       <= grant[1];
            last_grant <= grant[1];
         end

         if (state == MAC && tap != LAST_TAP) begin
            tap <= tap + 1'b1;
         end else begin
            tap <= '0;
         end

         if (state == WAIT) begin
            out_data_q <= bus.dp_result;
            out_chan_q <= chan;
         end

         if (out_hs) begin
            if (out_chan_q) begin
               cnt1 <= cnt1 + 1'b1;
            end else begin
               cnt0 <= cnt0 + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fir_chan_sched.sv
// tb_fir_chan_sched -- scoreboard bench for fir_chan_sched.
// A small datapath model answers dp_result: on each accumulate cycle it adds
// (dp_sample << 20) + dp_tap, so a full 16-tap run on sample s gives
// (s << 24) + 120, e.g. 0x05 -> 0x05000078.
module tb_fir_chan_sched;

   typedef struct {
      logic        chan;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] acc = '0;
   logic [15:0] cnt0Exp = '0;
   logic [15:0] cnt1Exp = '0;
   exp_t        expQ[$];
   int          checks = 0;
   int          failures = 0;

   fir_chan_sched_if #(.DW(8), .ACCW(32), .TAPW(4)) bus ();

   fir_chan_sched #(.NTAPS(16), .DW(8), .ACCW(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   // Datapath model driven by the scheduler's control outputs.
   always @(posedge clk) begin
      if (bus.dp_acc_clr) begin
         acc <= '0;
      end else if (bus.dp_acc_en) begin
         acc <= acc + ({24'd0, bus.dp_sample} << 20) + {28'd0, bus.dp_tap};
      end
   end
   assign bus.dp_result = acc;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic pushExpected(input logic chan, input logic [31:0] data);
      exp_t e;
      e.chan = chan;
      e.data = data;
      expQ.push_back(e);
   endtask

   // Called right after a negedge with inputs already driven; returns the
   // channel whose ready is seen, or -1 after the cycle budget.
   task automatic waitGrant(output int granted);
      granted = -1;
      for (int i = 0; i < 60; i++) begin
         #1;
         if (bus.ch0_ready) begin
            granted = 0;
            return;
         end
         if (bus.ch1_ready) begin
            granted = 1;
            return;
         end
         @(negedge clk);
      end
      checks++;
      failures++;
      $display("[TB] FAIL grant_timeout: got no ready expected a ready within 60 cycles");
   endtask

   // Offer one sample on one channel, check who is granted and record the
   // result the consumer should eventually see.
   task automatic applyStimulus(input int chan, input logic [7:0] data, input logic [31:0] expRes);
      int g;
      @(negedge clk);
      if (chan == 0) begin
         bus.ch0_valid = 1'b1;
         bus.ch0_data  = data;
      end else begin
         bus.ch1_valid = 1'b1;
         bus.ch1_data  = data;
      end
      waitGrant(g);
      checkOutput("grant", 64'(g), 64'(chan));
      if (g >= 0) pushExpected(chan[0], expRes);
      @(posedge clk);
      #1;
      bus.ch0_valid = 1'b0;
      bus.ch1_valid = 1'b0;
   endtask

   task automatic waitDrain();
      int n;
      n = 0;
      while (expQ.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (expQ.size() != 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL drain_timeout: got %0d pending expected 0", expQ.size());
      end
      repeat (2) @(negedge clk);
   endtask

   // Monitor: pops the scoreboard on every result handshake and checks that
   // a stalled result does not move.
   initial begin
      logic        stalled;
      logic [31:0] prevData;
      logic        prevChan;
      exp_t        e;
      stalled  = 1'b0;
      prevData = '0;
      prevChan = 1'b0;
      forever begin
         @(negedge clk);
         #3;
         if (rst) begin
            cnt0Exp = '0;
            cnt1Exp = '0;
            stalled = 1'b0;
         end else begin
            if (stalled && bus.out_valid) begin
               checkOutput("hold_data", 64'(bus.out_data), 64'(prevData));
               checkOutput("hold_chan", 64'(bus.out_chan), 64'(prevChan));
            end
            if (bus.out_valid && bus.out_ready) begin
               if (expQ.size() == 0) begin
                  checks++;
                  failures++;
                  $display("[TB] FAIL unexpected_result: got data 0x%0h chan %0d expected none",
                           bus.out_data, bus.out_chan);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("out_data", 64'(bus.out_data), 64'(e.data));
                  checkOutput("out_chan", 64'(bus.out_chan), 64'(e.chan));
                  if (e.chan) cnt1Exp = cnt1Exp + 16'd1;
                  else        cnt0Exp = cnt0Exp + 16'd1;
               end
            end
            stalled  = bus.out_valid && !bus.out_ready;
            prevData = bus.out_data;
            prevChan = bus.out_chan;
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got no finish expected finish before 100000");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int g;
      int loads;
      int r1;
      int ovs;
      logic [7:0]  d0Tab[2];
      logic [7:0]  d1Tab[2];
      logic [31:0] expTab[4];

      bus.ch0_valid = 1'b0;
      bus.ch0_data  = '0;
      bus.ch1_valid = 1'b0;
      bus.ch1_data  = '0;
      bus.out_ready = 1'b1;

      // Outputs during reset, with a channel requesting.
      repeat (2) @(negedge clk);
      bus.ch0_valid = 1'b1;
      #1;
      checkOutput("rst_ready0", 64'(bus.ch0_ready), 64'd0);
      checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("rst_dp_load", 64'(bus.dp_load), 64'd0);
      checkOutput("rst_out_data", 64'(bus.out_data), 64'd0);
      checkOutput("rst_cnt0", 64'(dut.cnt0), 64'd0);
      bus.ch0_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // Single ch0 sample 0x05: cycle-by-cycle control sequence.
      @(negedge clk);
      bus.ch0_valid = 1'b1;
      bus.ch0_data  = 8'h05;
      #1;
      checkOutput("t_ready0", 64'(bus.ch0_ready), 64'd1);
      checkOutput("t_ready1", 64'(bus.ch1_ready), 64'd0);
      pushExpected(1'b0, 32'h0500_0078);
      @(negedge clk);
      bus.ch0_valid = 1'b0;
      #1;
      checkOutput("load", 64'(bus.dp_load), 64'd1);
      checkOutput("acc_clr", 64'(bus.dp_acc_clr), 64'd1);
      checkOutput("dp_sample", 64'(bus.dp_sample), 64'h05);
      checkOutput("dp_chan", 64'(bus.dp_chan), 64'd0);
      checkOutput("load_tap", 64'(bus.dp_tap), 64'd0);
      checkOutput("load_ready0", 64'(bus.ch0_ready), 64'd0);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         #1;
         checkOutput("mac_en", 64'(bus.dp_acc_en), 64'd1);
         checkOutput("mac_tap", 64'(bus.dp_tap), 64'(i));
         checkOutput("mac_load", 64'(bus.dp_load), 64'd0);
      end
      @(negedge clk);
      #1;
      checkOutput("wait_en", 64'(bus.dp_acc_en), 64'd0);
      checkOutput("wait_tap", 64'(bus.dp_tap), 64'd0);
      checkOutput("wait_out_valid", 64'(bus.out_valid), 64'd0);
      @(negedge clk);
      #1;
      checkOutput("out_valid_t19", 64'(bus.out_valid), 64'd1);
      @(negedge clk);
      bus.ch0_valid = 1'b1;
      bus.ch0_data  = 8'h33;
      #1;
      checkOutput("ready_t20", 64'(bus.ch0_ready), 64'd1);
      checkOutput("out_valid_t20", 64'(bus.out_valid), 64'd0);
      pushExpected(1'b0, 32'h3300_0078);
      @(posedge clk);
      #1;
      bus.ch0_valid = 1'b0;
      waitDrain();

      // Both channels continuously valid: grants alternate 0,1,0,1.
      // last_grant is 0 here, so reset the block to start from ch0 priority.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      d0Tab[0] = 8'h3C; d0Tab[1] = 8'h11;
      d1Tab[0] = 8'hA7; d1Tab[1] = 8'hFF;
      expTab[0] = 32'h3C00_0078; expTab[1] = 32'hA700_0078;
      expTab[2] = 32'h1100_0078; expTab[3] = 32'hFF00_0078;
      @(negedge clk);
      bus.ch0_valid = 1'b1;
      bus.ch0_data  = d0Tab[0];
      bus.ch1_valid = 1'b1;
      bus.ch1_data  = d1Tab[0];
      for (int k = 0; k < 4; k++) begin
         waitGrant(g);
         checkOutput("alt_grant", 64'(g), 64'(k % 2));
         pushExpected(k[0], expTab[k]);
         @(posedge clk);
         #1;
         if (k == 0) bus.ch0_data = d0Tab[1];
         if (k == 1) bus.ch1_data = d1Tab[1];
         if (k == 2) bus.ch0_valid = 1'b0;
         if (k == 3) bus.ch1_valid = 1'b0;
         @(negedge clk);
      end
      waitDrain();

      // Consumer stalls for 10 cycles while ch0 keeps requesting.
      bus.out_ready = 1'b0;
      applyStimulus(1, 8'h42, 32'h4200_0078);
      for (int i = 0; i < 40 && !bus.out_valid; i++) begin
         @(negedge clk);
         #1;
      end
      checkOutput("stall_reach_out", 64'(bus.out_valid), 64'd1);
      bus.ch0_valid = 1'b1;
      bus.ch0_data  = 8'h07;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #1;
         checkOutput("stall_valid", 64'(bus.out_valid), 64'd1);
         checkOutput("stall_ready0", 64'(bus.ch0_ready), 64'd0);
         checkOutput("stall_ready1", 64'(bus.ch1_ready), 64'd0);
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      #1;
      checkOutput("release_ready0", 64'(bus.ch0_ready), 64'd0);
      @(negedge clk);
      #1;
      checkOutput("idle_after_release", 64'(bus.ch0_ready), 64'd1);
      checkOutput("idle_out_valid", 64'(bus.out_valid), 64'd0);
      pushExpected(1'b0, 32'h0700_0078);
      @(posedge clk);
      #1;
      bus.ch0_valid = 1'b0;
      waitDrain();

      // ch1_valid toggling while busy must not be accepted.
      @(negedge clk);
      bus.ch0_valid = 1'b1;
      bus.ch0_data  = 8'h21;
      waitGrant(g);
      checkOutput("toggle_grant", 64'(g), 64'd0);
      pushExpected(1'b0, 32'h2100_0078);
      @(posedge clk);
      #1;
      bus.ch0_valid = 1'b0;
      loads = 0;
      r1 = 0;
      bus.ch1_data = 8'h99;
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         bus.ch1_valid = (i % 2 == 0);
         #1;
         if (bus.ch1_ready) r1++;
         if (bus.dp_load) loads++;
      end
      bus.ch1_valid = 1'b0;
      checkOutput("toggle_ch1_ready", 64'(r1), 64'd0);
      checkOutput("toggle_loads", 64'(loads), 64'd1);
      waitDrain();
      checkOutput("cnt0_mid", 64'(dut.cnt0), 64'(cnt0Exp));
      checkOutput("cnt1_mid", 64'(dut.cnt1), 64'(cnt1Exp));

      // Reset during MAC at tap 7; last grant was ch0, so without the reset
      // a tie would go to ch1.
      @(negedge clk);
      bus.ch0_valid = 1'b1;
      bus.ch0_data  = 8'h66;
      waitGrant(g);
      checkOutput("abort_grant", 64'(g), 64'd0);
      pushExpected(1'b0, 32'h6600_0078);
      @(posedge clk);
      #1;
      bus.ch0_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         #1;
         if (bus.dp_acc_en && bus.dp_tap == 4'd7) break;
      end
      checkOutput("abort_at_tap7", 64'(bus.dp_tap), 64'd7);
      rst = 1'b1;
      #1;
      checkOutput("abort_rst_tap", 64'(bus.dp_tap), 64'd0);
      checkOutput("abort_rst_en", 64'(bus.dp_acc_en), 64'd0);
      void'(expQ.pop_back());
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("post_rst_en", 64'(bus.dp_acc_en), 64'd0);
      checkOutput("post_rst_load", 64'(bus.dp_load), 64'd0);
      checkOutput("post_rst_tap", 64'(bus.dp_tap), 64'd0);
      checkOutput("post_rst_sample", 64'(bus.dp_sample), 64'd0);
      checkOutput("post_rst_out_data", 64'(bus.out_data), 64'd0);
      checkOutput("post_rst_ready", 64'({bus.ch1_ready, bus.ch0_ready}), 64'd0);
      ovs = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         #1;
         if (bus.out_valid) ovs++;
      end
      checkOutput("abort_no_result", 64'(ovs), 64'd0);
      @(negedge clk);
      bus.ch0_valid = 1'b1;
      bus.ch0_data  = 8'h0A;
      bus.ch1_valid = 1'b1;
      bus.ch1_data  = 8'h0B;
      waitGrant(g);
      checkOutput("fresh_grant", 64'(g), 64'd0);
      pushExpected(1'b0, 32'h0A00_0078);
      @(posedge clk);
      #1;
      bus.ch0_valid = 1'b0;
      @(negedge clk);
      waitGrant(g);
      checkOutput("fresh_grant2", 64'(g), 64'd1);
      pushExpected(1'b1, 32'h0B00_0078);
      @(posedge clk);
      #1;
      bus.ch1_valid = 1'b0;
      waitDrain();
      checkOutput("cnt0_after_rst", 64'(dut.cnt0), 64'd1);
      checkOutput("cnt1_after_rst", 64'(dut.cnt1), 64'd1);

      // Counter wrap: preload cnt0 near the top, then deliver three ch0 results.
      @(negedge clk);
      force dut.cnt0 = 16'hFFFD;
      cnt0Exp = 16'hFFFD;
      @(negedge clk);
      release dut.cnt0;
      #1;
      checkOutput("cnt0_preload", 64'(dut.cnt0), 64'hFFFD);
      applyStimulus(0, 8'h01, 32'h0100_0078);
      applyStimulus(0, 8'h02, 32'h0200_0078);
      applyStimulus(0, 8'h03, 32'h0300_0078);
      waitDrain();
      checkOutput("cnt0_wrap", 64'(dut.cnt0), 64'h0000);
      checkOutput("cnt0_model", 64'(dut.cnt0), 64'(cnt0Exp));
      checkOutput("cnt1_unchanged", 64'(dut.cnt1), 64'(cnt1Exp));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
